mont_redc_serial: RTL and testbench

- Bit-serial Montgomery reduction (REDC) stage directly downstream of the 10x10 registered unsigned multiplier.
- Consumes the 2W-bit product T and the odd modulus N. Returns R_OUT = T * 2^-W mod N, fully reduced to the range [0, N).
- Uses a valid/ready handshake on both sides, with one transaction in flight at a time.

---
 rtl/mont_redc_serial.sv | 116 +++++++++++
 tb/tb_mont_redc_serial.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_redc_serial.sv
// Bit-serial Montgomery reduction: r_out = t_in * 2^-W mod n_in, one REDC step per cycle.
// Single transaction in flight, valid/ready on both sides.
module mont_redc_serial #(
  parameter int unsigned W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   t_in,
  input  logic [W-1:0]     n_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     r_out,
  output logic             err
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    FINAL  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2*W:0]    a_q, a_d;
  logic [W-1:0]    n_q, n_d;
  logic [CW-1:0]   i_q, i_d;
  logic [W-1:0]    r_q, r_d;
  logic            err_q, err_d;
  logic            ov_q, ov_d;

  logic            legal;
  logic [2*W:0]    n_ext;
  logic [2*W:0]    a_sum;

  assign n_ext = {{(W + 1){1'b0}}, n_q};
  assign a_sum = a_q + (a_q[0] ? n_ext : '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    n_d     = n_q;
    i_d     = i_q;
    r_d     = r_q;
    err_d   = err_q;
    ov_d    = ov_q;
    // An even modulus (including zero) has no inverse of 2; t >= N*R breaks A < 2N.
    legal   = n_in[0] && (t_in < {n_in, {W{1'b0}}});

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (legal) begin
            a_d     = {1'b0, t_in};
            n_d     = n_in;
            i_d     = '0;
            state_d = REDUCE;
          end else begin
            r_d     = '0;
            err_d   = 1'b1;
            ov_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      REDUCE: begin
        a_d = a_sum >> 1;
        i_d = i_q + CW'(1);
        if (i_q == CW'(W - 1)) state_d = FINAL;
      end
      FINAL: begin
        // A < 2N, so the low W bits of the difference are exact.
        r_d     = (a_q >= n_ext) ? (a_q[W-1:0] - n_q) : a_q[W-1:0];
        err_d   = 1'b0;
        ov_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      n_q     <= n_d;
      i_q     <= i_d;
      r_q     <= r_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign r_out     = r_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mont_redc_serial.sv
// Directed checks for mont_redc_serial: latency, boundaries, illegal inputs,
// back-pressure, mid-operation reset and back-to-back throughput.
module tb_mont_redc_serial;

  localparam int unsigned W = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2*W-1:0]  t_in = '0;
  logic [W-1:0]    n_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [W-1:0]    r_out;
  logic            err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mont_redc_serial #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .t_in      (t_in),
    .n_in      (n_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r_out     (r_out),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present one transfer while in IDLE; returns at the negedge after the accept edge.
  task automatic send(input logic [2*W-1:0] t, input logic [W-1:0] n);
    @(negedge clk);
    t_in = t;
    n_in = n;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen; 999 on timeout.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = 999;
  endtask

  task automatic finish_handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || r_out !== '0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b r_out=%0d err=%b, want 1 0 0 0",
               in_ready, out_valid, r_out, err);
    end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    send(20'd12345, 10'd1009);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_in_ready_drop: got %b want 0", in_ready);
    end
    wait_out(lat);
    checks++;
    if (lat != 11) begin
      failures++;
      $display("FAIL basic_latency: got %0d want 11", lat);
    end
    checks++;
    if (r_out !== 10'd823 || err !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: r_out=%0d err=%b want 823 0", r_out, err);
    end
    finish_handshake();
  endtask

  task automatic test_boundary();
    logic [2*W-1:0] tv [3] = '{20'd0, 20'd1024, 20'd1033215};
    logic [W-1:0]   ev [3] = '{10'd0, 10'd1, 10'd269};
    int lat;
    for (int k = 0; k < 3; k++) begin
      send(tv[k], 10'd1009);
      wait_out(lat);
      checks++;
      if (lat != 11 || r_out !== ev[k] || err !== 1'b0) begin
        failures++;
        $display("FAIL boundary_t%0d: lat=%0d r_out=%0d err=%b want 11 %0d 0",
                 tv[k], lat, r_out, err, ev[k]);
      end
      finish_handshake();
    end
  endtask

  task automatic test_illegal();
    logic [2*W-1:0] tv [3] = '{20'd5, 20'd3072, 20'd0};
    logic [W-1:0]   nv [3] = '{10'd1008, 10'd3, 10'd0};
    int lat;
    for (int k = 0; k < 3; k++) begin
      send(tv[k], nv[k]);
      wait_out(lat);
      checks++;
      if (lat != 0 || err !== 1'b1 || r_out !== '0) begin
        failures++;
        $display("FAIL illegal_n%0d_t%0d: lat=%0d err=%b r_out=%0d want 0 1 0",
                 nv[k], tv[k], lat, err, r_out);
      end
      finish_handshake();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    send(20'd12345, 10'd1009);
    wait_out(lat);
    for (int c = 0; c < 5; c++) begin
      t_in = 20'd5;
      n_in = 10'd1009;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || r_out !== 10'd823 || err !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold%0d: out_valid=%b r_out=%0d err=%b in_ready=%b want 1 823 0 0",
                 c, out_valid, r_out, err, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_no_accept: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b1;
    send(20'd999, 10'd1009);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || r_out !== '0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b r_out=%0d err=%b want 0 1 0 0",
               out_valid, in_ready, r_out, err);
    end
    rst_n = 1'b1;
    send(20'd12345, 10'd1009);
    wait_out(lat);
    checks++;
    if (lat != 11 || r_out !== 10'd823 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_fresh: lat=%0d r_out=%0d err=%b want 11 823 0", lat, r_out, err);
    end
    finish_handshake();
  endtask

  task automatic test_back_to_back();
    int unsigned n, t, r;
    int acc, prev_acc, waited, lat;
    logic ok;
    out_ready = 1'b1;
    prev_acc = 0;
    @(negedge clk);
    n = $urandom_range(1023, 1) | 1;
    t = $urandom_range(n * 1024 - 1, 0);
    t_in = 20'(t);
    n_in = 10'(n);
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      waited = 0;
      while (!in_ready && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      acc = cyc + 1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(lat);
      r = 32'(r_out);
      ok = (lat == 11) && (err === 1'b0) && (r < n) && (((r * 1024) % n) == (t % n));
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL b2b_result%0d: t=%0d n=%0d lat=%0d r_out=%0d err=%b want r*1024%%n==t%%n, r<n, lat 11",
                 k, t, n, lat, r, err);
      end
      if (k > 0) begin
        checks++;
        if (acc - prev_acc != 13) begin
          failures++;
          $display("FAIL b2b_spacing%0d: got %0d want 13", k, acc - prev_acc);
        end
      end
      prev_acc = acc;
      if (k < 49) begin
        n = $urandom_range(1023, 1) | 1;
        t = $urandom_range(n * 1024 - 1, 0);
        t_in = 20'(t);
        n_in = 10'(n);
        in_valid = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
